// File: rtl/time_mgr_pkg.sv
// Shared Time_Manager definitions: FSM state encoding, default counter width
// and the BUSY/DONE output levels used by all Time_Manager blocks.
package time_mgr_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic BUSY_ON  = 1'b1;
    localparam logic BUSY_OFF = 1'b0;
    localparam logic DONE_ON  = 1'b1;
    localparam logic DONE_OFF = 1'b0;

endpackage

// File: rtl/clk_en_gen_if.sv
// Control/status bundle between a burst sequencer (master) and the
// clock-enable generator (slave).
interface clk_en_gen_if
    import time_mgr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] DIV;
    logic [CNT_W-1:0] BURST;
    logic             CLK_ENO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, STOP, DIV, BURST,
        input  CLK_ENO, BUSY, DONE
    );

    modport slave (
        input  START, STOP, DIV, BURST,
        output CLK_ENO, BUSY, DONE
    );
endinterface

// File: rtl/clk_en_div_cnt.sv
// Modulo-(i_mod+1) period counter with synchronous clear/load and a
// terminal-count flag that is high while the count equals i_mod.
module clk_en_div_cnt
    import time_mgr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_mod,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == i_mod);
    assign o_tc = w_tc;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, regardless of block ordering in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Burst clock-enable generator: emits registered single-cycle enables every
// DIV+1 cycles for BURST pulses (0 = until STOP) to a latch-based clock gate.
module clk_en_gen
    import time_mgr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         CLK_IN,
    input  logic         RST_N,
    clk_en_gen_if.slave  bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic             r_clk_en;
    logic             r_busy;
    logic             r_done;

    logic             w_start;
    logic             w_run;
    logic             w_last;
    logic             w_tc;

    assign w_start = (r_state == IDLE) && bus.START && !bus.STOP;
    assign w_run   = (r_state == RUN);
    // Subtracting from B avoids the overflow that pulse_cnt+1 == B would hit.
    assign w_last  = r_clk_en && (r_burst != '0) &&
                     (r_pulse_cnt == r_burst - CNT_W'(1));

    clk_en_div_cnt #(.CNT_W(CNT_W)) u_div_cnt (
        .clk        (CLK_IN),
        .rst_n      (RST_N),
        .i_clr      (w_start),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_run),
        .i_mod      (r_div),
        .o_tc       (w_tc)
    );

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_burst     <= '0;
            r_pulse_cnt <= '0;
            r_clk_en    <= 1'b0;
            r_busy      <= BUSY_OFF;
            r_done      <= DONE_OFF;
        end else begin
            r_done <= DONE_OFF;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= RUN;
                        r_div       <= bus.DIV;
                        r_burst     <= bus.BURST;
                        r_pulse_cnt <= '0;
                        r_clk_en    <= 1'b1;
                        r_busy      <= BUSY_ON;
                    end
                end
                RUN: begin
                    if (bus.STOP) begin
                        r_state  <= IDLE;
                        r_clk_en <= 1'b0;
                        r_busy   <= BUSY_OFF;
                    end else if (w_last) begin
                        r_state  <= IDLE;
                        r_clk_en <= 1'b0;
                        r_busy   <= BUSY_OFF;
                        r_done   <= DONE_ON;
                    end else begin
                        if (r_clk_en) begin
                            r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
                        end
                        r_clk_en <= w_tc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.CLK_ENO = r_clk_en;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;

endmodule
